alu_cmd_framer: RTL and testbench
=================================

Name: alu_cmd_framer

Overview:
- Upstream stage of the logical operation unit in the UART ALU.
- Consumes the byte stream from the UART receiver and assembles fixed-format command frames.
- Each frame carries: header, opcode, operand A, operand B.
- Presents opcode/a/b to the logic unit with a valid/ready handshake, and flags malformed, timed-out or dropped traffic.

Parameters:
- N, 16, operand width in bits; must be a multiple of 8, range 8..32; OPB = N/8 bytes per operand.
- HDR_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum allowed clk cycles between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART RX
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- op_valid  out  1  command available to logic unit
- op_ready  in  1  logic unit accepts command
- opcode  out  4  operation select (0 AND … 6 NOT)
- a  out  N  operand A, signed
- b  out  N  operand B, signed
- busy  out  1  high whenever state != IDLE
- frame_err  out  1  one-cycle pulse: frame aborted (bad opcode byte, timeout, checksum)
- drop_err  out  1  one-cycle pulse: byte discarded while command pending

Behaviour:
- Reset values: clk/rst only as decided. rst (synchronous, active-high) forces state=IDLE; op_valid, frame_err, drop_err, busy = 0; opcode, a, b = 0; byte and gap counters = 0. rst mid-frame discards the partial frame with no error pulse.
- Frame format, MSB byte first: HDR_BYTE, OPC, A[N-1:N-8] … A[7:0], B[N-1:N-8] … B[7:0].
- IDLE: bytes other than HDR_BYTE are ignored silently. HDR_BYTE -> OPC.
- OPC:
  - Byte upper nibble != 0 -> frame_err pulse, go to IDLE.
  - Otherwise latch the low nibble into the shadow opcode, byte counter = 0, go to OPA.
- OPA: shift the byte into the shadow A. After OPB bytes -> OPB_S, counter = 0.
- OPB_S: shift the byte into the shadow B. After OPB bytes -> ISSUE (or CHK when the optional feature is enabled).
- ISSUE:
  - Entering ISSUE copies the shadows to opcode/a/b and sets op_valid.
  - Latency: op_valid is high in the cycle after the rx_valid of the last frame byte.
  - opcode/a/b are held stable while op_valid=1.
  - op_valid & op_ready -> op_valid=0 next cycle, go to IDLE.
- Bytes arriving in ISSUE while op_ready=0: discarded, drop_err pulses the next cycle.
- Byte arriving in the same cycle as the accepting op_ready=1: processed as an IDLE byte. HDR_BYTE goes directly to OPC.
- Gap timeout:
  - Active in OPC, OPA, OPB_S, CHK. The counter clears on every rx_valid and on state entry.
  - When the count reaches TIMEOUT_CYCLES -> frame_err pulse, go to IDLE.
  - An rx_valid in the expiry cycle wins: the byte is processed and the counter is cleared.
- A HDR_BYTE value inside a frame is treated as data (no resync).
- Errors pulse for exactly one cycle, registered.

Optional Feature:
- Macro: ALU_FRAMER_CHECKSUM_EN.
- Defined:
  - One extra CHK byte follows B. It must equal the XOR of all bytes from OPC through the last B byte.
  - Match -> ISSUE; latency is measured from the CHK byte.
  - Mismatch -> frame_err pulse, go to IDLE, no command issued. The gap timeout also applies in CHK.
- Not defined: no CHK state, no checksum logic; the frame ends at the last B byte.

Decomposition:
- Package alu_uart_pkg:
  - HDR_BYTE default.
  - State encoding localparams: IDLE, OPC, OPA, OPB_S, CHK, ISSUE.
  - Opcode constants AND_OP=0 … NOT_OP=6, shared with the logic unit.
- Sub-module byte_gap_timer:
  - Inputs: clear, enable. Output: expire.
  - Parameterised by TIMEOUT_CYCLES.
  - Counter width = $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Basic frame: bytes A5 02 12 34 00 FF, op_ready=1. Next cycle: op_valid=1, opcode=2, a=16'h1234, b=16'h00FF. op_valid drops the cycle after.
- Backpressure: the same frame with op_ready=0 for 20 cycles, then a byte 55 arrives. Response: outputs stay stable, drop_err pulses once. op_ready=1 -> IDLE, and busy=0 once the handshake completes.
- Bad opcode: A5 17 -> frame_err pulse, busy=0, no op_valid. A following valid frame is accepted normally.
- Timeout: with TIMEOUT_CYCLES=50, send A5 03 12 and stall 50 cycles -> frame_err. A byte at exactly cycle 50 instead is accepted, and the frame completes.
- Back-to-back: the second frame's A5 arrives in the accept cycle of the first. The second command issues correctly (opcode=6, a=16'h8000, b=16'h0000).
- With ALU_FRAMER_CHECKSUM_EN: A5 00 FF FF 0F 0F 00 -> issue, a=16'hFFFF, b=16'h0F0F. CHK byte 01 instead -> frame_err, no op_valid.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART ALU: frame header, framer state codes, logic-unit opcodes.
package alu_uart_pkg;

    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] OPC   = 3'd1;
    localparam logic [2:0] OPA   = 3'd2;
    localparam logic [2:0] OPB_S = 3'd3;
    localparam logic [2:0] CHK   = 3'd4;
    localparam logic [2:0] ISSUE = 3'd5;

    localparam logic [3:0] AND_OP  = 4'd0;
    localparam logic [3:0] OR_OP   = 4'd1;
    localparam logic [3:0] XOR_OP  = 4'd2;
    localparam logic [3:0] NAND_OP = 4'd3;
    localparam logic [3:0] NOR_OP  = 4'd4;
    localparam logic [3:0] XNOR_OP = 4'd5;
    localparam logic [3:0] NOT_OP  = 4'd6;

    // States in which the inter-byte gap is policed.
    function automatic logic gap_timed_state(input logic [2:0] s);
        return (s == OPC) || (s == OPA) || (s == OPB_S) || (s == CHK);
    endfunction

endpackage

// File: rtl/alu_cmd_framer_byte_gap_timer.sv
// Inter-byte gap timer: expire is asserted on the TIMEOUT_CYCLES-th enabled cycle without a clear.
module byte_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    assign expire = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (!expire) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_cmd_framer.sv
// Byte-stream to command framer for the ALU logic unit (HDR, OPC, A, B[, CHK]).
// Optional trailing XOR checksum byte enabled by `define ALU_FRAMER_CHECKSUM_EN.
module alu_cmd_framer
    import alu_uart_pkg::*;
#(
    parameter int unsigned N              = 16,
    parameter logic [7:0]  HDR_BYTE       = alu_uart_pkg::DEFAULT_HDR_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [3:0]          opcode,
    output logic signed [N-1:0] a,
    output logic signed [N-1:0] b,
    output logic                busy,
    output logic                frame_err,
    output logic                drop_err
);

    localparam int unsigned OPB  = N / 8;
    localparam logic [2:0]  LAST = 3'(OPB - 1);

    logic [2:0]   state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [3:0]   opc_sh_q, opc_sh_d;
    logic [N-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [3:0]   opcode_q, opcode_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic         op_valid_q, op_valid_d;
    logic         frame_err_q, frame_err_d;
    logic         drop_err_q, drop_err_d;
    logic         gap_expire;
`ifdef ALU_FRAMER_CHECKSUM_EN
    logic [7:0]   chk_q, chk_d;
`endif

    byte_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || (state_d != state_q)),
        .enable (gap_timed_state(state_q)),
        .expire (gap_expire)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opc_sh_d    = opc_sh_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        op_valid_d  = op_valid_q;
        frame_err_d = 1'b0;
        drop_err_d  = 1'b0;
`ifdef ALU_FRAMER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        // A byte in the expiry cycle wins; the timer only fires on a silent cycle.
        if (gap_expire && !rx_valid) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid && rx_data == HDR_BYTE) state_d = OPC;
                end
                OPC: begin
                    if (rx_valid) begin
                        if (rx_data[7:4] != 4'h0) begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            opc_sh_d = rx_data[3:0];
                            cnt_d    = '0;
                            state_d  = OPA;
`ifdef ALU_FRAMER_CHECKSUM_EN
                            chk_d    = rx_data;
`endif
                        end
                    end
                end
                OPA: begin
                    if (rx_valid) begin
                        a_sh_d = N'({a_sh_q, rx_data});
`ifdef ALU_FRAMER_CHECKSUM_EN
                        chk_d  = chk_q ^ rx_data;
`endif
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = OPB_S;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                OPB_S: begin
                    if (rx_valid) begin
                        b_sh_d = N'({b_sh_q, rx_data});
`ifdef ALU_FRAMER_CHECKSUM_EN
                        chk_d  = chk_q ^ rx_data;
`endif
                        if (cnt_q == LAST) begin
                            cnt_d = '0;
`ifdef ALU_FRAMER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d    = ISSUE;
                            op_valid_d = 1'b1;
                            opcode_d   = opc_sh_q;
                            a_d        = a_sh_q;
                            b_d        = b_sh_d;
`endif
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
`ifdef ALU_FRAMER_CHECKSUM_EN
                CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_q) begin
                            state_d    = ISSUE;
                            op_valid_d = 1'b1;
                            opcode_d   = opc_sh_q;
                            a_d        = a_sh_q;
                            b_d        = b_sh_q;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
`endif
                ISSUE: begin
                    // The accept cycle already behaves as IDLE for an incoming byte.
                    if (op_ready) begin
                        op_valid_d = 1'b0;
                        state_d    = (rx_valid && rx_data == HDR_BYTE) ? OPC : IDLE;
                    end else if (rx_valid) begin
                        drop_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opc_sh_q    <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            opcode_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_err_q  <= 1'b0;
`ifdef ALU_FRAMER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opc_sh_q    <= opc_sh_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_valid_q  <= op_valid_d;
            frame_err_q <= frame_err_d;
            drop_err_q  <= drop_err_d;
`ifdef ALU_FRAMER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign op_valid  = op_valid_q;
    assign opcode    = opcode_q;
    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_alu_cmd_framer.sv
// Directed-vector bench for alu_cmd_framer (N=16, TIMEOUT_CYCLES=50); honours ALU_FRAMER_CHECKSUM_EN.
module tb_alu_cmd_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  opcode;
    logic [15:0] a_o, b_o;
    logic        busy, frame_err, drop_err;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    alu_cmd_framer #(
        .N              (16),
        .HDR_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .a         (a_o),
        .b         (b_o),
        .busy      (busy),
        .frame_err (frame_err),
        .drop_err  (drop_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_body(input logic [3:0] opc, input logic [15:0] av, input logic [15:0] bv);
        logic [7:0] chk;
        chk = {4'h0, opc} ^ av[15:8] ^ av[7:0] ^ bv[15:8] ^ bv[7:0];
        send_byte({4'h0, opc});
        send_byte(av[15:8]);
        send_byte(av[7:0]);
        send_byte(bv[15:8]);
        send_byte(bv[7:0]);
`ifdef ALU_FRAMER_CHECKSUM_EN
        send_byte(chk);
`else
        chk = 8'h00;
`endif
    endtask

    task automatic send_frame(input logic [3:0] opc, input logic [15:0] av, input logic [15:0] bv);
        send_byte(8'hA5);
        send_body(opc, av, bv);
    endtask

    task automatic check_issue(input string tag, input logic [3:0] opc, input logic [15:0] av, input logic [15:0] bv);
        check({tag, ".op_valid"}, 32'(op_valid), 32'd1);
        check({tag, ".opcode"}, 32'(opcode), 32'(opc));
        check({tag, ".a"}, 32'(a_o), 32'(av));
        check({tag, ".b"}, 32'(b_o), 32'(bv));
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        op_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.op_valid", 32'(op_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.frame_err", 32'(frame_err), 32'd0);
        check("rst.drop_err", 32'(drop_err), 32'd0);
        check("rst.opcode", 32'(opcode), 32'd0);
        check("rst.a", 32'(a_o), 32'd0);
        check("rst.b", 32'(b_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Non-header bytes are ignored in IDLE
        send_byte(8'h12);
        check("idle_ign.busy", 32'(busy), 32'd0);

        // Basic frame
        send_frame(4'h2, 16'h1234, 16'h00FF);
        check_issue("basic", 4'h2, 16'h1234, 16'h00FF);
        check("basic.busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("basic.op_valid_drop", 32'(op_valid), 32'd0);
        check("basic.busy_drop", 32'(busy), 32'd0);

        // Backpressure with a dropped byte
        op_ready = 1'b0;
        send_frame(4'h4, 16'hBEEF, 16'h0102);
        check_issue("bp", 4'h4, 16'hBEEF, 16'h0102);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp.hold_valid", 32'(op_valid), 32'd1);
            check("bp.hold_a", 32'(a_o), 32'h0000BEEF);
        end
        send_byte(8'h55);
        check("bp.drop_err", 32'(drop_err), 32'd1);
        check_issue("bp.after_drop", 4'h4, 16'hBEEF, 16'h0102);
        @(negedge clk);
        check("bp.drop_once", 32'(drop_err), 32'd0);
        op_ready = 1'b1;
        @(negedge clk);
        check("bp.accept_valid", 32'(op_valid), 32'd0);
        check("bp.accept_busy", 32'(busy), 32'd0);

        // Bad opcode byte
        send_byte(8'hA5);
        send_byte(8'h17);
        check("badop.frame_err", 32'(frame_err), 32'd1);
        check("badop.busy", 32'(busy), 32'd0);
        check("badop.op_valid", 32'(op_valid), 32'd0);
        @(negedge clk);
        check("badop.err_once", 32'(frame_err), 32'd0);
        send_frame(4'h1, 16'hABCD, 16'h1234);
        check_issue("after_bad", 4'h1, 16'hABCD, 16'h1234);
        @(negedge clk);

        // Header value inside a frame is data
        send_frame(4'h4, 16'hA5A5, 16'h0001);
        check_issue("hdr_data", 4'h4, 16'hA5A5, 16'h0001);
        @(negedge clk);

        // Reset mid-frame: no error pulse, partial frame lost
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.frame_err", 32'(frame_err), 32'd0);
        @(negedge clk);
        check("midrst.frame_err2", 32'(frame_err), 32'd0);

        // Gap timeout expires after 50 silent cycles
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h12);
        repeat (49) @(negedge clk);
        check("tmo.pre_err", 32'(frame_err), 32'd0);
        check("tmo.pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("tmo.frame_err", 32'(frame_err), 32'd1);
        check("tmo.busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("tmo.err_once", 32'(frame_err), 32'd0);

        // Byte in the expiry cycle is accepted
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h12);
        repeat (49) @(negedge clk);
        send_byte(8'h34);
        check("tmo_edge.frame_err", 32'(frame_err), 32'd0);
        check("tmo_edge.busy", 32'(busy), 32'd1);
        send_byte(8'h56);
        send_byte(8'h78);
`ifdef ALU_FRAMER_CHECKSUM_EN
        send_byte(8'h0B);
`endif
        check_issue("tmo_edge", 4'h3, 16'h1234, 16'h5678);
        @(negedge clk);
        check("tmo_edge.op_valid_drop", 32'(op_valid), 32'd0);

        // Back-to-back: next header lands in the accept cycle
        op_ready = 1'b0;
        send_frame(4'h5, 16'h1122, 16'h3344);
        check_issue("b2b.first", 4'h5, 16'h1122, 16'h3344);
        op_ready = 1'b1;
        send_byte(8'hA5);
        check("b2b.accept_valid", 32'(op_valid), 32'd0);
        check("b2b.accept_busy", 32'(busy), 32'd1);
        check("b2b.no_drop", 32'(drop_err), 32'd0);
        send_body(4'h6, 16'h8000, 16'h0000);
        check_issue("b2b.second", 4'h6, 16'h8000, 16'h0000);
        @(negedge clk);
        check("b2b.op_valid_drop", 32'(op_valid), 32'd0);

`ifdef ALU_FRAMER_CHECKSUM_EN
        begin
            logic [7:0] good [7];
            good = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h00};
            foreach (good[i]) send_byte(good[i]);
            check_issue("chk.good", 4'h0, 16'hFFFF, 16'h0F0F);
            @(negedge clk);
            good[6] = 8'h01;
            foreach (good[i]) send_byte(good[i]);
            check("chk.bad_err", 32'(frame_err), 32'd1);
            check("chk.bad_valid", 32'(op_valid), 32'd0);
            check("chk.bad_busy", 32'(busy), 32'd0);
            @(negedge clk);
            check("chk.bad_valid2", 32'(op_valid), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
